// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state, op encodings and cycle-count helper for muldiv_unit
package muldiv_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;
   function automatic int muldiv_k(input int width, input int unroll);
      return width / unroll;
   endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one restoring-divide or shift-add step, consuming one operand bit MSB first
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 op,
   input  logic [2*WIDTH-1:0]   part_in,
   input  logic [WIDTH-1:0]     opnd,
   input  logic                 next_bit,
   output logic [2*WIDTH-1:0]   part_out,
   output logic                 q_bit
);
   logic [WIDTH:0]       sh;
   logic [WIDTH:0]       diff;
   logic [2*WIDTH-1:0]   acc;
   always_comb begin
      sh = {part_in[WIDTH-1:0], next_bit};
      diff = sh - {1'b0, opnd};
      acc = {part_in[2*WIDTH-2:0], 1'b0} + (next_bit ? {{WIDTH{1'b0}}, opnd} : '0);
      q_bit = op == OP_DIV && !diff[WIDTH];
      part_out = op == OP_DIV ? {{WIDTH{1'b0}}, q_bit ? diff[WIDTH-1:0] : sh[WIDTH-1:0]} : acc;
   end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide retiring UNROLL bits per cycle, with cancel
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int UNROLL = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_flag,
   input  logic                 cancel_flag,
   input  logic                 op,
   input  logic                 signed_flag,
   input  logic [WIDTH-1:0]     opdata1,
   input  logic [WIDTH-1:0]     opdata2,
   output logic                 busy,
   output logic                 complete_flag,
   output logic                 div_zero,
   output logic [2*WIDTH-1:0]   result
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'((muldiv_k(WIDTH, UNROLL) - 1) * UNROLL);
   state_t               state;
   logic [CW-1:0]        counter;
   logic                 op_r, neg_res, neg_rem;
   logic [WIDTH-1:0]     src, opnd, mag1, mag2, src_nx, quo, rem;
   logic [2*WIDTH-1:0]   part, part_nx, final_res;
   assign mag1 = signed_flag && opdata1[WIDTH-1] ? -opdata1 : opdata1;
   assign mag2 = signed_flag && opdata2[WIDTH-1] ? -opdata2 : opdata2;
   // src holds dividend/multiplier bits; quotient bits shift in from the bottom as they are consumed
   for (genvar i = 0; i < UNROLL; i++) begin : g_step
      logic [2*WIDTH-1:0] p_in, p_out;
      logic [WIDTH-1:0]   s_in, s_out;
      logic               q;
      if (i == 0) begin : g_first
         assign p_in = part;
         assign s_in = src;
      end else begin : g_next
         assign p_in = g_step[i-1].p_out;
         assign s_in = g_step[i-1].s_out;
      end
      muldiv_step #(.WIDTH(WIDTH)) u_step (
         .op       (op_r),
         .part_in  (p_in),
         .opnd     (opnd),
         .next_bit (s_in[WIDTH-1]),
         .part_out (p_out),
         .q_bit    (q)
      );
      assign s_out = {s_in[WIDTH-2:0], q};
   end
   assign part_nx = g_step[UNROLL-1].p_out;
   assign src_nx = g_step[UNROLL-1].s_out;
   assign quo = src_nx;
   assign rem = part_nx[WIDTH-1:0];
   assign final_res = op_r == OP_DIV ? {neg_rem ? -rem : rem, neg_res ? -quo : quo}
                                     : (neg_res ? -part_nx : part_nx);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         counter <= '0;
         busy <= 1'b0;
         complete_flag <= 1'b0;
         div_zero <= 1'b0;
         result <= '0;
         op_r <= OP_MUL;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         src <= '0;
         opnd <= '0;
         part <= '0;
      end else begin
         case (state)
            IDLE: if (start_flag && !cancel_flag) begin
               busy <= 1'b1;
               if (op == OP_DIV && opdata2 == '0) begin
                  state <= DONE;
                  complete_flag <= 1'b1;
                  div_zero <= 1'b1;
                  result <= '0;
               end else begin
                  state <= CALC;
                  div_zero <= 1'b0;
                  op_r <= op;
                  neg_res <= signed_flag && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                  neg_rem <= signed_flag && opdata1[WIDTH-1];
                  src <= mag1;
                  opnd <= mag2;
                  part <= '0;
                  counter <= '0;
               end
            end
            CALC: if (cancel_flag) begin
               state <= IDLE;
               busy <= 1'b0;
               div_zero <= 1'b0;
            end else begin
               part <= part_nx;
               src <= src_nx;
               counter <= counter + CW'(UNROLL);
               if (counter == LAST) begin
                  state <= DONE;
                  complete_flag <= 1'b1;
                  result <= final_res;
               end
            end
            DONE: if (cancel_flag || !start_flag) begin
               state <= IDLE;
               busy <= 1'b0;
               complete_flag <= 1'b0;
               if (cancel_flag) div_zero <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed table plus random sweep for UNROLL=1 and UNROLL=4 instances
module tb_muldiv_unit;
   import muldiv_pkg::*;
   logic clk = 1'b0, rst_n = 1'b0, start_flag = 1'b0, cancel_flag = 1'b0, op = 1'b0, signed_flag = 1'b0;
   logic [31:0] opdata1 = '0, opdata2 = '0;
   logic busy1, complete1, div_zero1, busy4, complete4, div_zero4;
   logic [63:0] result1, result4;
   int checks = 0, failures = 0;
   typedef struct {
      logic        op;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      logic        dz;
   } vec_t;
   vec_t vecs[14];
   muldiv_unit #(.WIDTH(32), .UNROLL(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start_flag(start_flag), .cancel_flag(cancel_flag), .op(op),
      .signed_flag(signed_flag), .opdata1(opdata1), .opdata2(opdata2), .busy(busy1),
      .complete_flag(complete1), .div_zero(div_zero1), .result(result1)
   );
   muldiv_unit #(.WIDTH(32), .UNROLL(4)) u4 (
      .clk(clk), .rst_n(rst_n), .start_flag(start_flag), .cancel_flag(cancel_flag), .op(op),
      .signed_flag(signed_flag), .opdata1(opdata1), .opdata2(opdata2), .busy(busy4),
      .complete_flag(complete4), .div_zero(div_zero4), .result(result4)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask
   function automatic logic [63:0] model(input logic o, input logic s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = s ? longint'($signed(a)) : longint'({32'b0, a});
      sb = s ? longint'($signed(b)) : longint'({32'b0, b});
      if (o == OP_DIV) begin
         if (b == 0) return 64'd0;
         q = sa / sb;
         r = sa % sb;
         res = {r[31:0], q[31:0]};
      end else begin
         q = sa * sb;
         res = q;
      end
      return res;
   endfunction
   task automatic run_op(input string nm, input logic o, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input logic dz);
      int t1, t4;
      @(negedge clk);
      op = o; signed_flag = s; opdata1 = a; opdata2 = b; start_flag = 1'b1;
      t1 = 0; t4 = 0;
      for (int c = 1; c <= 60 && (t1 == 0 || t4 == 0); c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            opdata1 = $urandom; opdata2 = $urandom; op = ~o; signed_flag = ~s;
         end
         if (t1 == 0 && complete1) t1 = c;
         if (t4 == 0 && complete4) t4 = c;
      end
      chk({nm, "_lat1"}, 64'(t1), dz ? 64'd1 : 64'd33);
      chk({nm, "_lat4"}, 64'(t4), dz ? 64'd1 : 64'd9);
      chk({nm, "_res1"}, result1, exp);
      chk({nm, "_res4"}, result4, exp);
      chk({nm, "_dz"}, {62'b0, div_zero1, div_zero4}, {62'b0, dz, dz});
      @(negedge clk);
      start_flag = 1'b0;
      @(posedge clk); #1;
      chk({nm, "_idle"}, {60'b0, busy1, complete1, busy4, complete4}, 64'd0);
   endtask
   initial begin
      logic o, s, any_fail;
      logic [31:0] a, b;
      vecs[0]  = '{1'b1, 1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 32'hFFFFFFFF,   32'd2,        64'hFFFFFFFF_FFFFFFFE, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 32'hFFFFFFFF,   32'd2,        64'h00000001_FFFFFFFE, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 32'd1000,       32'd1000,     64'h00000000_000F4240, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 32'd12345,      32'd0,        64'h00000000_00000000, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 32'h80000000,   32'h80000000, 64'h40000000_00000000, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 32'hFFFFFFFD,   32'd5,        64'hFFFFFFFF_FFFFFFF1, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 32'd5,          32'd10,       64'h00000005_00000000, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 32'hFFFFFFFF,   32'd2,        64'h00000001_7FFFFFFF, 1'b0};
      #12;
      chk("reset1", {busy1, complete1, div_zero1, result1[60:0]}, 64'd0);
      chk("reset4", {busy4, complete4, div_zero4, result4[60:0]}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].dz);
      // divide by zero held in DONE, then cancelled there
      @(negedge clk);
      op = OP_DIV; signed_flag = 1'b0; opdata1 = 32'd5; opdata2 = 32'd0; start_flag = 1'b1;
      @(posedge clk); #1;
      chk("dz_done", {61'b0, complete1, div_zero1, busy1}, 64'd7);
      repeat (3) @(posedge clk);
      #1;
      chk("dz_hold", {60'b0, complete1, div_zero1, complete4, div_zero4}, 64'hF);
      @(negedge clk);
      cancel_flag = 1'b1;
      @(posedge clk); #1;
      chk("dz_cancel", {58'b0, busy1, complete1, div_zero1, busy4, complete4, div_zero4}, 64'd0);
      @(negedge clk);
      cancel_flag = 1'b0; start_flag = 1'b0;
      // cancel beats start in IDLE
      @(negedge clk);
      start_flag = 1'b1; cancel_flag = 1'b1; op = OP_MUL;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_cancel", {62'b0, busy1, busy4}, 64'd0);
      @(negedge clk);
      start_flag = 1'b0; cancel_flag = 1'b0;
      // cancel on CALC cycle 10 keeps prior result
      run_op("pre_cancel", OP_MUL, 1'b0, 32'd3, 32'd5, 64'd15, 1'b0);
      @(negedge clk);
      op = OP_DIV; signed_flag = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start_flag = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      cancel_flag = 1'b1; start_flag = 1'b0;
      @(posedge clk); #1;
      chk("cancel_state", {60'b0, busy1, complete1, div_zero1, busy4}, 64'd0);
      chk("cancel_keep", result1, 64'd15);
      cancel_flag = 1'b0;
      run_op("post_cancel", OP_DIV, 1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 1'b0);
      // asynchronous reset mid-CALC
      @(negedge clk);
      op = OP_MUL; signed_flag = 1'b0; opdata1 = 32'hFFFFFFFF; opdata2 = 32'd2; start_flag = 1'b1;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid1", {busy1, complete1, div_zero1, result1[60:0]}, 64'd0);
      chk("rst_mid4", {busy4, complete4, div_zero4, result4[60:0]}, 64'd0);
      chk("rst_res_hi", {result1[63:61], result4[63:61]}, 64'd0);
      @(negedge clk);
      start_flag = 1'b0; rst_n = 1'b1;
      // random sweep against the behavioural model
      any_fail = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         o = 1'($urandom_range(0, 1));
         s = 1'($urandom_range(0, 1));
         a = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 40)) : $urandom;
         b = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
         run_op($sformatf("rnd%0d", n), o, s, a, b, model(o, s, a, b), o == OP_DIV && b == 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
